dspi_ctrl_node: RTL and testbench

//  Parametrised single-direction DSPI pipeline node. It sits between two DSPI modules in a chain.
//  - Passes data packets through a PIPE_STAGES-deep pipeline.
//  - Owns a bank of NUM_REGS 32-bit control registers, reached by relative-addressed control packets.
//  - Answers control reads with absolute CP_A_CTRL_READ_RESPONSE_32b packets.
//  - Forwards foreign packets with ChannelID decremented.
//  - Relays the backward instruction path with one register stage.

---
 rtl/dspi_pkg.sv | 33 +++
 rtl/dspi_ctrl_regfile.sv | 70 +++++++
 rtl/dspi_ctrl_node.sv | 174 +++++++++++++++++
 tb/tb_dspi_ctrl_node.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dspi_pkg.sv
// Shared DSPI definitions: packet type codes, control opcodes, instruction
// commands and control-register layout.
package dspi_pkg;

   localparam logic [2:0] INSTRUCTION_CMD_IDLE    = 3'd0;
   localparam logic [2:0] INSTRUCTION_CMD_REQUEST = 3'd1;
   localparam logic [2:0] INSTRUCTION_CMD_RELEASE = 3'd2;

   localparam logic [1:0] TYPE_IDLE    = 2'b00;
   localparam logic [1:0] TYPE_DATA    = 2'b01;
   localparam logic [1:0] TYPE_CTRL    = 2'b10;
   localparam logic [1:0] TYPE_ILLEGAL = 2'b11;
   localparam int TYPE_DATA_BIT = 0;
   localparam int TYPE_CTRL_BIT = 1;

   // Opcodes live in the ChunkID bits below the relative-addressing flag
   localparam int CP_A_CTRL_READ_RESPONSE_32b = 1;
   localparam int CP_A_EOS                    = 2;
   localparam int CP_R_CTRL_WRITE_32b         = 1;
   localparam int CP_R_CTRL_READ_REQUEST_32b  = 2;

   localparam int REG_MODULE_ID = 0;
   localparam int REG_STATUS    = 1;
   localparam int REG_COUNTER   = 2;
   localparam int REG_SCRATCH   = 3;
   localparam int REG_GEN_BASE  = 4;

   localparam int ST_ILLEGAL_TYPE = 0;
   localparam int ST_BAD_OP       = 1;
   localparam int ST_BAD_ADDR     = 2;
   localparam int ST_W            = 3;

endpackage

// File: rtl/dspi_ctrl_regfile.sv
// Control register bank: ID, sticky W1C status, data counter, scratch and
// general cfg registers. Single write port, combinational read port.
module dspi_ctrl_regfile
   import dspi_pkg::*;
#(
   parameter int          NUM_REGS  = 8,
   parameter logic [31:0] MODULE_ID = 32'h0,
   parameter int          RA_W      = $clog2(NUM_REGS)
)(
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         we,
   input  logic [RA_W-1:0]              waddr,
   input  logic [31:0]                  wdata,
   input  logic [RA_W-1:0]              raddr,
   output logic [31:0]                  rdata,
   input  logic                         cnt_inc,
   input  logic [ST_W-1:0]              st_set,
   output logic [32*(NUM_REGS-4)-1:0]   cfg_regs
);

   localparam int NUM_GEN = NUM_REGS - 4;

   logic [ST_W-1:0]             status_q;
   logic [31:0]                 counter_q;
   logic [31:0]                 scratch_q;
   logic [NUM_GEN-1:0][31:0]    gen_q;
   logic [ST_W-1:0]             w1c;

   assign w1c = (we && waddr == RA_W'(REG_STATUS)) ? wdata[ST_W-1:0] : '0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         status_q  <= '0;
         counter_q <= '0;
         scratch_q <= '0;
         gen_q     <= '0;
      end else begin
         // new events in the same cycle survive the clear
         status_q <= (status_q & ~w1c) | st_set;
         if (we && waddr == RA_W'(REG_COUNTER))
            counter_q <= '0;
         else if (cnt_inc)
            counter_q <= counter_q + 32'd1;
         if (we && waddr == RA_W'(REG_SCRATCH))
            scratch_q <= wdata;
         for (int i = 0; i < NUM_GEN; i++)
            if (we && waddr == RA_W'(i + REG_GEN_BASE))
               gen_q[i] <= wdata;
      end
   end

   always_comb begin
      rdata = '0;
      case (raddr)
         RA_W'(REG_MODULE_ID): rdata = MODULE_ID;
         RA_W'(REG_STATUS):    rdata = 32'(status_q);
         RA_W'(REG_COUNTER):   rdata = counter_q;
         RA_W'(REG_SCRATCH):   rdata = scratch_q;
         default: begin
            for (int i = 0; i < NUM_GEN; i++)
               if (raddr == RA_W'(i + REG_GEN_BASE))
                  rdata = gen_q[i];
         end
      endcase
   end

   assign cfg_regs = gen_q;

endmodule

// File: rtl/dspi_ctrl_node.sv
// DSPI pipeline node: decode stage feeding a fixed-latency shift pipeline,
// local control register bank and a one-stage backward instruction relay.
module dspi_ctrl_node
   import dspi_pkg::*;
#(
   parameter int          DATA_WIDTH                  = 512,
   parameter int          STREAM_ID_NUM               = 16,
   parameter int          CHUNK_ID_NUM                = 32,
   parameter int          CHANNEL_ID_NUM              = 1024,
   parameter int          STATE_WIDTH                 = 32,
   parameter int          INSTRUCTION_WIDTH           = 3,
   parameter int          INSTRUCTION_PARAMETER_WIDTH = 16,
   parameter int          PIPE_STAGES                 = 2,
   parameter int          NUM_REGS                    = 8,
   parameter logic [31:0] MODULE_ID                   = 32'h0,
   localparam int SID_W = $clog2(STREAM_ID_NUM),
   localparam int CK_W  = $clog2(CHUNK_ID_NUM),
   localparam int CH_W  = $clog2(CHANNEL_ID_NUM),
   localparam int RA_W  = $clog2(NUM_REGS)
)(
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic [DATA_WIDTH-1:0]                  Front_Data,
   input  logic [1:0]                             Front_Type,
   input  logic                                   Front_Last,
   input  logic [SID_W-1:0]                       Front_StreamID,
   input  logic [CK_W-1:0]                        Front_ChunkID,
   input  logic [CH_W-1:0]                        Front_ChannelID,
   input  logic [STATE_WIDTH-1:0]                 Front_State,
   output logic [DATA_WIDTH-1:0]                  Back_Data,
   output logic [1:0]                             Back_Type,
   output logic                                   Back_Last,
   output logic [SID_W-1:0]                       Back_StreamID,
   output logic [CK_W-1:0]                        Back_ChunkID,
   output logic [CH_W-1:0]                        Back_ChannelID,
   output logic [STATE_WIDTH-1:0]                 Back_State,
   input  logic [INSTRUCTION_WIDTH-1:0]           Back_InstructionType,
   input  logic [SID_W-1:0]                       Back_InstructionStreamID,
   input  logic [CH_W-1:0]                        Back_InstructionChannelID,
   input  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Back_InstructionParameter,
   output logic [INSTRUCTION_WIDTH-1:0]           Front_InstructionType,
   output logic [SID_W-1:0]                       Front_InstructionStreamID,
   output logic [CH_W-1:0]                        Front_InstructionChannelID,
   output logic [INSTRUCTION_PARAMETER_WIDTH-1:0] Front_InstructionParameter,
   output logic [32*(NUM_REGS-4)-1:0]             cfg_regs,
   output logic                                   eos_pulse
);

   localparam int OP_W      = CK_W - 1;
   localparam int NUM_LANES = DATA_WIDTH / 32;

   typedef struct packed {
      logic [1:0]             typ;
      logic [SID_W-1:0]       sid;
      logic [CK_W-1:0]        ck;
      logic [CH_W-1:0]        ch;
      logic [STATE_WIDTH-1:0] st;
      logic                   last;
      logic [DATA_WIDTH-1:0]  data;
   } pkt_t;

   pkt_t                  dec_pkt, out_pkt;
   pkt_t                  pipe_q [1:PIPE_STAGES];
   logic [PIPE_STAGES:1]  vld_pipe;
   logic                  dec_vld;

   logic                  rf_we, cnt_inc, addr_ok;
   logic [31:0]           rf_rdata, rd_val;
   logic [ST_W-1:0]       st_set;
   logic [OP_W-1:0]       op;

   assign addr_ok = Front_State < STATE_WIDTH'(NUM_REGS);
   assign rd_val  = addr_ok ? rf_rdata : 32'h0;
   assign op      = Front_ChunkID[OP_W-1:0];

   always_comb begin
      dec_pkt = '{typ: Front_Type, sid: Front_StreamID, ck: Front_ChunkID,
                  ch: Front_ChannelID, st: Front_State, last: Front_Last,
                  data: Front_Data};
      dec_vld = 1'b0;
      rf_we   = 1'b0;
      cnt_inc = 1'b0;
      st_set  = '0;
      case (Front_Type)
         TYPE_DATA: begin
            dec_vld = 1'b1;
            cnt_inc = 1'b1;
         end
         TYPE_CTRL: begin
            if (!Front_ChunkID[CK_W-1]) begin
               dec_vld = 1'b1;
            end else if (Front_ChannelID != '0) begin
               dec_vld    = 1'b1;
               dec_pkt.ch = Front_ChannelID - CH_W'(1);
            end else if (op == OP_W'(CP_R_CTRL_WRITE_32b)) begin
               rf_we                = addr_ok;
               st_set[ST_BAD_ADDR]  = !addr_ok;
            end else if (op == OP_W'(CP_R_CTRL_READ_REQUEST_32b)) begin
               // reply in place of the request; State keeps the address
               dec_vld              = 1'b1;
               dec_pkt.ck           = {1'b0, OP_W'(CP_A_CTRL_READ_RESPONSE_32b)};
               dec_pkt.ch           = '0;
               dec_pkt.data         = {NUM_LANES{rd_val}};
               st_set[ST_BAD_ADDR]  = !addr_ok;
            end else begin
               st_set[ST_BAD_OP]    = 1'b1;
            end
         end
         TYPE_ILLEGAL: st_set[ST_ILLEGAL_TYPE] = 1'b1;
         default: ;
      endcase
   end

   dspi_ctrl_regfile #(
      .NUM_REGS  (NUM_REGS),
      .MODULE_ID (MODULE_ID),
      .RA_W      (RA_W)
   ) u_regfile (
      .clk      (clk),
      .rstn     (rstn),
      .we       (rf_we),
      .waddr    (Front_State[RA_W-1:0]),
      .wdata    (Front_Data[31:0]),
      .raddr    (Front_State[RA_W-1:0]),
      .rdata    (rf_rdata),
      .cnt_inc  (cnt_inc),
      .st_set   (st_set),
      .cfg_regs (cfg_regs)
   );

   // payload only moves with a valid slot; bubbles are masked at the output
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vld_pipe <= '0;
         for (int i = 1; i <= PIPE_STAGES; i++)
            pipe_q[i] <= '0;
      end else begin
         vld_pipe[1] <= dec_vld;
         if (dec_vld)
            pipe_q[1] <= dec_pkt;
         for (int i = 2; i <= PIPE_STAGES; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            if (vld_pipe[i-1])
               pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign out_pkt        = pipe_q[PIPE_STAGES];
   assign Back_Type      = vld_pipe[PIPE_STAGES] ? out_pkt.typ : TYPE_IDLE;
   assign Back_Data      = out_pkt.data;
   assign Back_Last      = out_pkt.last;
   assign Back_StreamID  = out_pkt.sid;
   assign Back_ChunkID   = out_pkt.ck;
   assign Back_ChannelID = out_pkt.ch;
   assign Back_State     = out_pkt.st;
   assign eos_pulse      = (Back_Type == TYPE_CTRL) && !out_pkt.ck[CK_W-1] &&
                           (out_pkt.ck[OP_W-1:0] == OP_W'(CP_A_EOS));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         Front_InstructionType      <= INSTRUCTION_WIDTH'(INSTRUCTION_CMD_IDLE);
         Front_InstructionStreamID  <= '0;
         Front_InstructionChannelID <= '0;
         Front_InstructionParameter <= '0;
      end else begin
         Front_InstructionType      <= Back_InstructionType;
         Front_InstructionStreamID  <= Back_InstructionStreamID;
         Front_InstructionChannelID <= Back_InstructionChannelID;
         Front_InstructionParameter <= Back_InstructionParameter;
      end
   end

endmodule

// File: tb/tb_dspi_ctrl_node.sv
// Directed bench for dspi_ctrl_node with default parameters (2-stage pipe, 8 regs).
module tb_dspi_ctrl_node;

   logic         clk = 1'b0;
   logic         rstn;
   logic [511:0] Front_Data, Back_Data;
   logic [1:0]   Front_Type, Back_Type;
   logic         Front_Last, Back_Last;
   logic [3:0]   Front_StreamID, Back_StreamID;
   logic [4:0]   Front_ChunkID, Back_ChunkID;
   logic [9:0]   Front_ChannelID, Back_ChannelID;
   logic [31:0]  Front_State, Back_State;
   logic [2:0]   Back_InstructionType, Front_InstructionType;
   logic [3:0]   Back_InstructionStreamID, Front_InstructionStreamID;
   logic [9:0]   Back_InstructionChannelID, Front_InstructionChannelID;
   logic [15:0]  Back_InstructionParameter, Front_InstructionParameter;
   logic [127:0] cfg_regs;
   logic         eos_pulse;

   int checks   = 0;
   int failures = 0;
   logic [31:0] rv;

   dspi_ctrl_node dut (
      .clk(clk), .rstn(rstn),
      .Front_Data(Front_Data), .Front_Type(Front_Type), .Front_Last(Front_Last),
      .Front_StreamID(Front_StreamID), .Front_ChunkID(Front_ChunkID),
      .Front_ChannelID(Front_ChannelID), .Front_State(Front_State),
      .Back_Data(Back_Data), .Back_Type(Back_Type), .Back_Last(Back_Last),
      .Back_StreamID(Back_StreamID), .Back_ChunkID(Back_ChunkID),
      .Back_ChannelID(Back_ChannelID), .Back_State(Back_State),
      .Back_InstructionType(Back_InstructionType),
      .Back_InstructionStreamID(Back_InstructionStreamID),
      .Back_InstructionChannelID(Back_InstructionChannelID),
      .Back_InstructionParameter(Back_InstructionParameter),
      .Front_InstructionType(Front_InstructionType),
      .Front_InstructionStreamID(Front_InstructionStreamID),
      .Front_InstructionChannelID(Front_InstructionChannelID),
      .Front_InstructionParameter(Front_InstructionParameter),
      .cfg_regs(cfg_regs), .eos_pulse(eos_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] t, input logic [3:0] sid, input logic [4:0] ck,
                        input logic [9:0] ch, input logic [31:0] st, input logic [511:0] d);
      Front_Type = t; Front_StreamID = sid; Front_ChunkID = ck;
      Front_ChannelID = ch; Front_State = st; Front_Data = d; Front_Last = 1'b1;
   endtask

   task automatic idle();
      drive(2'b00, 4'd0, 5'd0, 10'd0, 32'd0, 512'd0);
      Front_Last = 1'b0;
   endtask

   // relative write at ChannelID 0 (op 1); the write is visible after one edge
   task automatic wr(input logic [31:0] a, input logic [31:0] v);
      drive(2'b10, 4'd1, 5'b10001, 10'd0, a, {480'd0, v});
      step();
      idle();
   endtask

   // relative read request (op 2); response sampled after two edges
   task automatic rd(input logic [31:0] a, output logic [31:0] v);
      drive(2'b10, 4'd6, 5'b10010, 10'd0, a, 512'd0);
      step();
      idle();
      step();
      v = Back_Data[31:0];
   endtask

   initial begin
      rstn = 1'b0;
      idle();
      Back_InstructionType = 3'd0; Back_InstructionStreamID = 4'd0;
      Back_InstructionChannelID = 10'd0; Back_InstructionParameter = 16'd0;
      #12;
      check("rst_back_type", Back_Type, 2'b00);
      check("rst_instr_type", Front_InstructionType, 3'd0);
      check("rst_eos", eos_pulse, 1'b0);
      check("rst_cfg", cfg_regs, 128'd0);
      step();
      rstn = 1'b1;
      step();

      // 1: data passes unchanged with latency 2
      drive(2'b01, 4'd3, 5'h03, 10'd7, 32'h55, {16{32'hA5A5A5A5}});
      step();
      idle();
      check("data_lat1_bubble", Back_Type, 2'b00);
      step();
      check("data_type", Back_Type, 2'b01);
      check("data_sid", Back_StreamID, 4'd3);
      check("data_ch", Back_ChannelID, 10'd7);
      check("data_payload", Back_Data, {16{32'hA5A5A5A5}});
      check("data_last", Back_Last, 1'b1);
      rd(32'd2, rv);
      check("counter_after_data", rv, 32'd1);

      // 2: relative write consumed, then read back as absolute response
      drive(2'b10, 4'd1, 5'b10001, 10'd0, 32'd4, {480'd0, 32'h1234});
      step();
      idle();
      check("cfg_after_write", cfg_regs[31:0], 32'h1234);
      step();
      check("write_bubble", Back_Type, 2'b00);
      rd(32'd4, rv);
      check("resp_type", Back_Type, 2'b10);
      check("resp_chunk", Back_ChunkID, 5'h01);
      check("resp_ch", Back_ChannelID, 10'd0);
      check("resp_state", Back_State, 32'd4);
      check("resp_sid", Back_StreamID, 4'd6);
      check("resp_data", Back_Data, {16{32'h1234}});

      // 3: relative read for a downstream node is forwarded with ChannelID-1
      drive(2'b10, 4'd2, 5'b10010, 10'd5, 32'd3, {16{32'hCAFE0001}});
      step();
      idle();
      step();
      check("fwd_type", Back_Type, 2'b10);
      check("fwd_ch", Back_ChannelID, 10'd4);
      check("fwd_chunk", Back_ChunkID, 5'b10010);
      check("fwd_data", Back_Data, {16{32'hCAFE0001}});
      rd(32'd1, rv);
      check("status_clean", rv, 32'd0);

      // register map behaviour
      wr(32'd3, 32'hDEADBEEF);
      rd(32'd3, rv);
      check("scratch_rw", rv, 32'hDEADBEEF);
      wr(32'd0, 32'hFFFF);
      rd(32'd0, rv);
      check("module_id_ro", rv, 32'h0);
      wr(32'd2, 32'h5);
      rd(32'd2, rv);
      check("counter_clear", rv, 32'd0);
      wr(32'd7, 32'h77);
      check("cfg_top", cfg_regs[127:96], 32'h77);

      // 4: out-of-range read returns 0 and flags status bit2, then W1C
      rd(32'd9, rv);
      check("oob_read_zero", rv, 32'd0);
      check("oob_state", Back_State, 32'd9);
      rd(32'd1, rv);
      check("status_bad_addr", rv, 32'd4);
      wr(32'd1, 32'h4);
      rd(32'd1, rv);
      check("status_w1c", rv, 32'd0);

      // unknown relative op at ChannelID 0 is dropped, flags bit1
      drive(2'b10, 4'd1, 5'b10101, 10'd0, 32'd3, 512'd0);
      step();
      idle();
      step();
      check("badop_bubble", Back_Type, 2'b00);
      rd(32'd1, rv);
      check("status_bad_op", rv, 32'd2);

      // 5: illegal type sandwiched between data packets
      drive(2'b01, 4'd1, 5'd0, 10'd1, 32'd0, {16{32'h11111111}});
      step();
      drive(2'b11, 4'd2, 5'd0, 10'd2, 32'd0, {16{32'h22222222}});
      step();
      check("nb_a_type", Back_Type, 2'b01);
      check("nb_a_data", Back_Data, {16{32'h11111111}});
      drive(2'b01, 4'd3, 5'd0, 10'd3, 32'd0, {16{32'h33333333}});
      step();
      check("illegal_bubble", Back_Type, 2'b00);
      idle();
      step();
      check("nb_c_type", Back_Type, 2'b01);
      check("nb_c_data", Back_Data, {16{32'h33333333}});
      rd(32'd1, rv);
      check("status_illegal", rv, 32'd3);
      rd(32'd2, rv);
      check("counter_two", rv, 32'd2);

      // absolute EOS forwarded intact with a pulse
      drive(2'b10, 4'd5, 5'b00010, 10'd3, 32'hAB, 512'd0);
      step();
      idle();
      check("eos_early", eos_pulse, 1'b0);
      step();
      check("eos_pulse", eos_pulse, 1'b1);
      check("eos_ch", Back_ChannelID, 10'd3);
      step();
      check("eos_end", eos_pulse, 1'b0);

      // 6: instruction relay
      Back_InstructionType = 3'd1; Back_InstructionStreamID = 4'd4;
      Back_InstructionChannelID = 10'd9; Back_InstructionParameter = 16'd7;
      #1;
      check("instr_not_yet", Front_InstructionType, 3'd0);
      step();
      check("instr_type", Front_InstructionType, 3'd1);
      check("instr_sid", Front_InstructionStreamID, 4'd4);
      check("instr_ch", Front_InstructionChannelID, 10'd9);
      check("instr_param", Front_InstructionParameter, 16'd7);

      // reset mid-stream clears everything at once
      drive(2'b01, 4'd1, 5'd0, 10'd0, 32'd0, {16{32'h44444444}});
      step();
      drive(2'b01, 4'd2, 5'd0, 10'd0, 32'd0, {16{32'h55555555}});
      step();
      check("pre_rst_type", Back_Type, 2'b01);
      rstn = 1'b0;
      #1;
      check("midrst_type", Back_Type, 2'b00);
      check("midrst_instr", Front_InstructionType, 3'd0);
      check("midrst_cfg", cfg_regs, 128'd0);
      idle();
      Back_InstructionType = 3'd0;
      step();
      rstn = 1'b1;
      step();
      check("post_rst_none1", Back_Type, 2'b00);
      step();
      check("post_rst_none2", Back_Type, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
